// File: rtl/effect_scheduler_if.sv
// Control/status bundle for effect_scheduler: pattern-table programming port,
// sequence control pulses and the interval code driven to the cut-off/cut-on effect.
interface effect_scheduler_if;
    // start/stop are single-cycle request pulses with no ready back-pressure.
    // They are sampled on every rising edge, and stop wins when both are high.
    // prog_we is a write strobe that the scheduler honours only outside RUN.
    logic       prog_we;
    logic [2:0] prog_addr;
    logic [4:0] prog_data;
    logic [2:0] last_step;
    logic       start;
    logic       stop;
    logic       loop;
    logic [1:0] interval_time;
    logic [2:0] step_index;
    logic       busy;
    logic       done;

    modport master (
        output prog_we, prog_addr, prog_data, last_step, start, stop, loop,
        input  interval_time, step_index, busy, done
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, last_step, start, stop, loop,
        output interval_time, step_index, busy, done
    );
endinterface

// File: rtl/effect_scheduler.sv
// Steps through an 8-entry table of {interval code, duration} with one-second ticks.
// Optional feature: define EFFECT_SCHED_LOOP_EN to let the loop input repeat the sequence.
module effect_scheduler #(
    parameter int TICK_DIV = 50000000
) (
    input  logic               CLOCK_50,
    input  logic               resetn,
    effect_scheduler_if.slave  bus,
    output logic [1:0]         state_dbg
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [4:0]      tbl [8];
    logic [TW-1:0]   tick_cnt, tick_cnt_n;
    logic [2:0]      sec_cnt, sec_cnt_n;
    logic [2:0]      step_q, step_n;
    logic [1:0]      intv_q, intv_n;
    logic            tick;
    logic            loop_active;
    logic [2:0]      step_inc;

    assign tick     = (tick_cnt == TICK_LAST);
    assign step_inc = step_q + 3'd1;

`ifdef EFFECT_SCHED_LOOP_EN
    assign loop_active = bus.loop;
`else
    // The port stays on the bundle but never influences the sequence.
    assign loop_active = 1'b0 & bus.loop;
`endif

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            tick_cnt <= '0;
            sec_cnt  <= '0;
            step_q   <= '0;
            intv_q   <= '0;
        end else begin
            state    <= state_n;
            tick_cnt <= tick_cnt_n;
            sec_cnt  <= sec_cnt_n;
            step_q   <= step_n;
            intv_q   <= intv_n;
        end
    end

    // Table is frozen while a sequence runs so a step never changes under itself.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 8; i++) tbl[i] <= '0;
        end else if (bus.prog_we && (state != RUN)) begin
            tbl[bus.prog_addr] <= bus.prog_data;
        end
    end

    always_comb begin
        state_n    = state;
        tick_cnt_n = tick_cnt;
        sec_cnt_n  = sec_cnt;
        step_n     = step_q;
        intv_n     = intv_q;
        case (state)
            IDLE, DONE: begin
                if (bus.stop) begin
                    state_n    = IDLE;
                    step_n     = '0;
                    intv_n     = '0;
                    tick_cnt_n = '0;
                    sec_cnt_n  = '0;
                end else if (bus.start) begin
                    state_n    = RUN;
                    step_n     = '0;
                    intv_n     = tbl[0][4:3];
                    sec_cnt_n  = tbl[0][2:0];
                    tick_cnt_n = '0;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_n    = IDLE;
                    step_n     = '0;
                    intv_n     = '0;
                    tick_cnt_n = '0;
                    sec_cnt_n  = '0;
                end else if (!tick) begin
                    tick_cnt_n = tick_cnt + 1'b1;
                end else begin
                    tick_cnt_n = '0;
                    if (sec_cnt != 3'd0) begin
                        sec_cnt_n = sec_cnt - 3'd1;
                    end else if (step_q < bus.last_step) begin
                        step_n    = step_inc;
                        intv_n    = tbl[step_inc][4:3];
                        sec_cnt_n = tbl[step_inc][2:0];
                    end else if (loop_active) begin
                        step_n    = '0;
                        intv_n    = tbl[0][4:3];
                        sec_cnt_n = tbl[0][2:0];
                    end else begin
                        // last_step may have been lowered mid-run; DONE reports its current value.
                        state_n = DONE;
                        step_n  = bus.last_step;
                        intv_n  = '0;
                    end
                end
            end
            default: begin
                state_n    = IDLE;
                step_n     = '0;
                intv_n     = '0;
                tick_cnt_n = '0;
                sec_cnt_n  = '0;
            end
        endcase
    end

    assign bus.interval_time = intv_q;
    assign bus.step_index    = step_q;
    assign bus.busy          = (state == RUN);
    assign bus.done          = (state == DONE);
    assign state_dbg         = state;
endmodule

// File: tb/tb_effect_scheduler.sv
// Bench for effect_scheduler: directed scenarios plus random traffic, each cycle
// compared against a cycle-countdown model of the step sequence.
module tb_effect_scheduler;
    localparam int TICK_DIV = 4;

    logic       CLOCK_50 = 1'b0;
    logic       resetn;
    logic [1:0] state_dbg;

    effect_scheduler_if bus();

    effect_scheduler #(.TICK_DIV(TICK_DIV)) dut (
        .CLOCK_50  (CLOCK_50),
        .resetn    (resetn),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // clock / reset
    always #10 CLOCK_50 = ~CLOCK_50;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: a step is a plain countdown of (duration+1)*TICK_DIV cycles
    int         m_state;   // 0 idle, 1 run, 2 done
    logic [2:0] m_step;
    logic [1:0] m_intv;
    int         m_remain;
    logic [4:0] m_tbl [8];
    logic [6:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_state  = 0;
        m_step   = '0;
        m_intv   = '0;
        m_remain = 0;
        for (int i = 0; i < 8; i++) m_tbl[i] = '0;
    endfunction

    function automatic void model_load(input logic [2:0] idx);
        m_step   = idx;
        m_intv   = m_tbl[idx][4:3];
        m_remain = (int'(m_tbl[idx][2:0]) + 1) * TICK_DIV;
    endfunction

    function automatic void model_edge();
        logic write_ok;
        logic loop_on;
        write_ok = (m_state != 1);
`ifdef EFFECT_SCHED_LOOP_EN
        loop_on = bus.loop;
`else
        loop_on = 1'b0;
`endif
        if (bus.stop) begin
            m_state = 0;
            m_step  = '0;
            m_intv  = '0;
        end else if (m_state != 1) begin
            if (bus.start) begin
                m_state = 1;
                model_load(3'd0);
            end
        end else begin
            m_remain--;
            if (m_remain == 0) begin
                if (m_step < bus.last_step) model_load(m_step + 3'd1);
                else if (loop_on)           model_load(3'd0);
                else begin
                    m_state = 2;
                    m_step  = bus.last_step;
                    m_intv  = '0;
                end
            end
        end
        if (bus.prog_we && write_ok) m_tbl[bus.prog_addr] = bus.prog_data;
        exp_q.push_back({m_intv, m_step, m_state == 1, m_state == 2});
    endfunction

    // one clock: model follows the edge, outputs sampled 1 time unit later
    task automatic cycle();
        logic [6:0] e;
        @(posedge CLOCK_50);
        if (!resetn) begin
            model_reset();
            exp_q.push_back('0);
        end else begin
            model_edge();
        end
        #1;
        e = exp_q.pop_front();
        check("interval_time", bus.interval_time, e[6:5]);
        check("step_index", bus.step_index, e[4:2]);
        check("busy", bus.busy, e[1]);
        check("done", bus.done, e[0]);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // driver tasks
    task automatic prog(input logic [2:0] addr, input logic [4:0] data);
        bus.prog_we   = 1'b1;
        bus.prog_addr = addr;
        bus.prog_data = data;
        cycle();
        bus.prog_we   = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        cycle();
        bus.stop = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_intv"}, bus.interval_time, 2'd0);
        check({tag, "_step"}, bus.step_index, 3'd0);
        check({tag, "_busy"}, bus.busy, 1'b0);
        check({tag, "_done"}, bus.done, 1'b0);
    endtask

    initial begin
        resetn        = 1'b0;
        bus.prog_we   = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = '0;
        bus.last_step = '0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.loop      = 1'b0;
        model_reset();
        cycles(2);
        check_all_zero("reset");
        resetn = 1'b1;
        cycles(2);

        // two-step sequence: interval 1 for 8 cycles, interval 3 for 4 cycles, then DONE
        prog(3'd0, 5'b01_001);
        prog(3'd1, 5'b11_000);
        bus.last_step = 3'd1;
        pulse_start();
        check("seq_first", bus.interval_time, 2'd1);
        cycles(7);
        check("seq_step0_end", bus.interval_time, 2'd1);
        cycle();
        check("seq_step1", bus.interval_time, 2'd3);
        check("seq_step1_idx", bus.step_index, 3'd1);
        cycles(3);
        check("seq_step1_end", bus.interval_time, 2'd3);
        cycle();
        check("seq_done", bus.done, 1'b1);
        check("seq_done_intv", bus.interval_time, 2'd0);
        check("seq_done_idx", bus.step_index, 3'd1);

        // stop on the cycle of the step-0 final tick, starting from DONE
        pulse_start();
        cycles(7);
        pulse_stop();
        check("stop_busy", bus.busy, 1'b0);
        check("stop_idx", bus.step_index, 3'd0);
        check("stop_intv", bus.interval_time, 2'd0);

        // start+stop together from IDLE: stop wins
        bus.start = 1'b1;
        pulse_stop();
        bus.start = 1'b0;
        check("start_stop_busy", bus.busy, 1'b0);

        // write during RUN is dropped, the same write in DONE is stored
        pulse_start();
        prog(3'd1, 5'b10_111);
        bus.start = 1'b1;      // start in RUN must not restart
        cycle();
        bus.start = 1'b0;
        cycles(6);
        check("lock_step1", bus.interval_time, 2'd3);
        cycles(4);
        check("lock_done", bus.done, 1'b1);
        prog(3'd1, 5'b10_111);
        pulse_start();
        cycles(8);
        check("stored_step1", bus.interval_time, 2'd2);
        cycles(32);
        check("stored_done", bus.done, 1'b1);

        // loop request with last_step=1
        prog(3'd1, 5'b11_000);
        bus.loop = 1'b1;
        pulse_start();
        cycles(24);
`ifdef EFFECT_SCHED_LOOP_EN
        check("loop_busy", bus.busy, 1'b1);
        check("loop_idx", bus.step_index, 3'd0);
`else
        check("noloop_done", bus.done, 1'b1);
        check("noloop_idx", bus.step_index, 3'd1);
`endif
        pulse_stop();
        bus.loop = 1'b0;

        // asynchronous reset between edges mid-RUN
        pulse_start();
        cycles(3);
        #4 resetn = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        cycles(2);
        resetn = 1'b1;
        bus.last_step = 3'd0;
        pulse_start();
        check("zero_tbl_busy", bus.busy, 1'b1);
        cycles(3);
        check("zero_tbl_intv", bus.interval_time, 2'd0);
        cycle();
        check("zero_tbl_done", bus.done, 1'b1);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bus.start     = ($urandom_range(0, 15) == 0);
            bus.stop      = ($urandom_range(0, 79) == 0);
            bus.prog_we   = ($urandom_range(0, 5) == 0);
            bus.prog_addr = 3'($urandom_range(0, 7));
            bus.prog_data = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 40) == 0) bus.last_step = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 100) == 0) bus.loop = ~bus.loop;
            cycle();
        end
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.prog_we = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/effect_scheduler.md
EFFECT_SCHEDULER -- requirements
Module: effect_scheduler

Interface
REQ-001 Parameter TICK_DIV, default 50000000, CLOCK_50 cycles per one-second tick.
REQ-002 CLOCK_50  input  1  system clock, all logic on rising edge.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 prog_we  input  1  pattern table write strobe.
REQ-005 prog_addr  input  3  table entry index 0..7.
REQ-006 prog_data  input  5  entry word: [4:3] interval code, [2:0] duration, where step length is duration+1 seconds.
REQ-007 last_step  input  3  index of the final step in the sequence.
REQ-008 start  input  1  one-cycle request to begin the sequence.
REQ-009 stop  input  1  one-cycle request to abort the sequence.
REQ-010 loop  input  1  repeat the sequence from step 0 after last_step (see Configuration).
REQ-011 interval_time  output  2  registered interval code driven to the cut-off/cut-on effect; 0 selects passthrough.
REQ-012 step_index  output  3  index of the current step.
REQ-013 busy  output  1  high in RUN.
REQ-014 done  output  1  high in DONE.

Function
REQ-015 States: IDLE, RUN, DONE; a single registered state register.
REQ-016 Table: 8 x 5-bit registers; a write takes effect at the rising edge where prog_we=1, only in IDLE or DONE; writes during RUN are dropped.
REQ-017 IDLE: interval_time=0, step_index=0, busy=0, done=0.
REQ-018 IDLE with start=1 and stop=0 -> RUN on the next edge; at that edge interval_time=table[0][4:3], step_index=0, the tick counter clears, and the seconds counter loads table[0][2:0].
REQ-019 RUN: the tick counter counts 0..TICK_DIV-1 and wraps; the wrap cycle is a tick.
REQ-020 On a tick with seconds counter>0, the seconds counter decrements.
REQ-021 On a tick with seconds counter=0 and step_index<last_step, the block advances: step_index+1, interval_time and seconds counter reload from the new entry, same edge.
REQ-022 Each step therefore lasts exactly (duration+1)*TICK_DIV cycles.
REQ-023 On a tick with seconds counter=0 and step_index=last_step: if looping is active, wrap to step 0 per REQ-021; otherwise -> DONE.
REQ-024 DONE: interval_time=0, done=1, step_index holds last_step; start -> RUN per REQ-018; stop -> IDLE.
REQ-025 stop=1 in RUN -> IDLE on the next edge, overriding any same-cycle tick; interval_time=0 at that edge.
REQ-026 start and stop both high in any state: stop wins.
REQ-027 start in RUN is ignored; the sequence does not restart.
REQ-028 last_step and loop are sampled on every tick, not latched at start.
REQ-029 last_step=0 is valid: a one-step sequence.
REQ-030 Table entries with an interval code of 0 are legal and output passthrough for that step.

Reset
REQ-031 resetn low asynchronously forces IDLE, all outputs 0, tick and seconds counters 0, and all table entries 0.
REQ-032 Reset asserted mid-RUN discards the sequence; after release the block waits in IDLE for start.

Configuration
REQ-033 Macro EFFECT_SCHED_LOOP_EN: when defined, loop=1 makes REQ-023 wrap to step 0 and the block never enters DONE on its own.
REQ-034 Without EFFECT_SCHED_LOOP_EN, the loop input is ignored (port still present) and REQ-023 always goes to DONE.

Verification (TICK_DIV=4)
REQ-035 Reset check: write entry 0=5'b01_001 and entry 1=5'b11_000, last_step=1, pulse start -> interval_time=1 for 8 cycles, then 3 for 4 cycles, then done=1 and interval_time=0.
REQ-036 Stop pre-emption: run per REQ-035, assert stop on the exact cycle of the step-0 final tick -> IDLE next edge, step_index stays 0, interval_time=0.
REQ-037 Write lockout: during RUN, write entry 1=5'b10_111 -> step 1 still outputs interval 3 for 4 cycles; after DONE the same write is stored.
REQ-038 Loop with EFFECT_SCHED_LOOP_EN defined: loop=1, last_step=1 -> step_index sequence 0,1,0,1 with done never set; the same stimulus without the macro -> done=1 after step 1.
REQ-039 Async reset: pull resetn low mid-RUN between clock edges -> outputs go 0 immediately; after release, the table reads back all zeros via a start with last_step=0, giving interval_time=0 for 4 cycles, then DONE.
